// File: rtl/spwtcr_tx_scheduler_if.sv
// Signal bundle between the SpaceWire TX scheduler and its neighbours:
// RX credit logic, TX FIFO, time-code source and TX encoder.
interface spwtcr_tx_scheduler_if;
    logic       enableTx;
    logic       runState;
    logic       gotFct;
    logic       tickIn;
    logic [7:0] timeIn;
    logic       sendFctReq;
    logic       sendFctAck;
    logic       fifo_empty;
    logic [8:0] fifo_data;
    logic       fifo_rd;
    logic       txReady;
    logic       txValid;
    logic [1:0] txType;
    logic [8:0] txData;
    logic [6:0] creditTx;
    logic       creditErrTx;
    logic [1:0] dbgState;

    // Encoder handshake: a character transfers on every rising edge where
    // txValid and txReady are both high; txType/txData hold steady while
    // txValid is high and txReady is low.
    modport slave (
        input  enableTx, runState, gotFct, tickIn, timeIn, sendFctReq,
        input  fifo_empty, fifo_data, txReady,
        output sendFctAck, fifo_rd, txValid, txType, txData,
        output creditTx, creditErrTx, dbgState
    );

    modport master (
        output enableTx, runState, gotFct, tickIn, timeIn, sendFctReq,
        output fifo_empty, fifo_data, txReady,
        input  sendFctAck, fifo_rd, txValid, txType, txData,
        input  creditTx, creditErrTx, dbgState
    );
endinterface

// File: rtl/spwtcr_tx_scheduler.sv
// SpaceWire transmit character scheduler: picks time-code, FCT, N-Char or NULL
// for each slot and tracks the transmit credit granted by received FCTs.
module spwtcr_tx_scheduler #(
    parameter int MAX_CREDIT = 56,
    parameter int FCT_CREDIT = 8
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    spwtcr_tx_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_SELECT = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    localparam logic [1:0] T_NULL  = 2'b00;
    localparam logic [1:0] T_FCT   = 2'b01;
    localparam logic [1:0] T_NCHAR = 2'b10;
    localparam logic [1:0] T_TIME  = 2'b11;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_sel_type;
    logic       w_fifo_rd;
    logic       w_done;
    logic       w_dec;
    logic [7:0] w_sum;

    logic [1:0] r_tx_type;
    logic [8:0] r_tx_data;
    logic [6:0] r_credit;
    logic       r_cred_err;
    logic       r_tick_pend;
    logic [7:0] r_time;

    // A transfer only counts while enabled; a held character is dropped on disable.
    assign w_done = (r_state == S_HOLD) && bus.txReady && bus.enableTx;
    assign w_dec  = w_done && (r_tx_type == T_NCHAR);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_sel_type = T_NULL;
        w_fifo_rd  = 1'b0;
        case (r_state)
            S_OFF: begin
                if (bus.enableTx) begin
                    w_next = S_SELECT;
                end
            end
            S_SELECT: begin
                if (r_tick_pend && bus.runState) begin
                    w_sel_type = T_TIME;
                end else if (bus.sendFctReq) begin
                    w_sel_type = T_FCT;
                end else if (bus.runState && !bus.fifo_empty && (r_credit != 7'd0)) begin
                    w_sel_type = T_NCHAR;
                    w_fifo_rd  = 1'b1;
                end
                w_next = S_HOLD;
            end
            S_HOLD: begin
                if (w_done) begin
                    w_next = S_SELECT;
                end
            end
            default: begin
                w_next = S_OFF;
            end
        endcase
        if (!bus.enableTx) begin
            w_next    = S_OFF;
            w_fifo_rd = 1'b0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET || (w_next == S_OFF)) begin
            r_tx_type <= T_NULL;
            r_tx_data <= 9'd0;
        end else if (r_state == S_SELECT) begin
            r_tx_type <= w_sel_type;
            case (w_sel_type)
                T_TIME:  r_tx_data <= {1'b0, r_time};
                T_NCHAR: r_tx_data <= bus.fifo_data;
                default: r_tx_data <= 9'd0;
            endcase
        end
    end

    // A new tick wins over clearing, so a tick landing on completion re-arms.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_tick_pend <= 1'b0;
            r_time      <= 8'd0;
        end else if (!bus.enableTx || (r_state == S_OFF)) begin
            r_tick_pend <= 1'b0;
        end else if (bus.tickIn) begin
            r_tick_pend <= 1'b1;
            r_time      <= bus.timeIn;
        end else if (w_done && (r_tx_type == T_TIME)) begin
            r_tick_pend <= 1'b0;
        end
    end

    assign w_sum = 8'(r_credit)
                 + (bus.gotFct ? 8'(FCT_CREDIT) : 8'd0)
                 - (w_dec ? 8'd1 : 8'd0);

    always_ff @(posedge CLOCK) begin
        if (RESET || !bus.enableTx || (r_state == S_OFF)) begin
            r_credit   <= 7'd0;
            r_cred_err <= 1'b0;
        end else if (w_sum > 8'(MAX_CREDIT)) begin
            r_cred_err <= 1'b1;
        end else begin
            r_credit <= w_sum[6:0];
        end
    end

    assign bus.txValid     = (r_state == S_HOLD);
    assign bus.txType      = r_tx_type;
    assign bus.txData      = r_tx_data;
    assign bus.fifo_rd     = w_fifo_rd;
    assign bus.sendFctAck  = w_done && (r_tx_type == T_FCT);
    assign bus.creditTx    = r_credit;
    assign bus.creditErrTx = r_cred_err;
    assign bus.dbgState    = r_state;

endmodule

// File: tb/tb_spwtcr_tx_scheduler.sv
// Directed bench for spwtcr_tx_scheduler: FIFO and encoder sink are modelled
// inside the single stimulus process, sampled on the falling clock edge.
module tb_spwtcr_tx_scheduler;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spwtcr_tx_scheduler_if bus();

    spwtcr_tx_scheduler #(
        .MAX_CREDIT (56),
        .FCT_CREDIT (8)
    ) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int ack_cnt = 0;
    int rd_cnt = 0;

    logic [8:0] fifo_q[$];
    logic [8:0] exp_q[$];
    logic [1:0] log_type[$];
    logic [8:0] log_data[$];
    logic [1:0] nn_type[$];
    logic [8:0] nn_data[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_fifo();
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 9'd0;
    endtask

    task automatic push(input logic [8:0] d);
        fifo_q.push_back(d);
        refresh_fifo();
    endtask

    task automatic clear_log();
        log_type.delete();
        log_data.delete();
    endtask

    // Falling edge: record handshakes; rising edge +1: pop FIFO; return at +2.
    task automatic step();
        logic rd;
        @(negedge clk);
        rd = bus.fifo_rd;
        if (rd) rd_cnt++;
        if (bus.sendFctAck) ack_cnt++;
        if (bus.txValid && bus.txReady && bus.enableTx) begin
            log_type.push_back(bus.txType);
            log_data.push_back(bus.txData);
        end
        @(posedge clk);
        #1;
        if (rd && (fifo_q.size() != 0)) void'(fifo_q.pop_front());
        refresh_fifo();
        #1;
    endtask

    task automatic filter_nonnull();
        nn_type.delete();
        nn_data.delete();
        for (int i = 0; i < log_type.size(); i++) begin
            if (log_type[i] != 2'b00) begin
                nn_type.push_back(log_type[i]);
                nn_data.push_back(log_data[i]);
            end
        end
    endtask

    initial begin
        int cnt;
        logic found;

        rst            = 1'b1;
        bus.enableTx   = 1'b0;
        bus.runState   = 1'b0;
        bus.gotFct     = 1'b0;
        bus.tickIn     = 1'b0;
        bus.timeIn     = 8'd0;
        bus.sendFctReq = 1'b0;
        bus.txReady    = 1'b0;
        refresh_fifo();

        // Reset and NULL stream
        step();
        step();
        chk("rst_valid", 32'(bus.txValid), 32'd0);
        chk("rst_type", 32'(bus.txType), 32'd0);
        chk("rst_credit", 32'(bus.creditTx), 32'd0);
        chk("rst_err", 32'(bus.creditErrTx), 32'd0);
        chk("rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
        chk("rst_ack", 32'(bus.sendFctAck), 32'd0);
        chk("rst_state", 32'(bus.dbgState), 32'd0);

        rst          = 1'b0;
        bus.enableTx = 1'b1;
        bus.txReady  = 1'b1;
        clear_log();
        step();
        chk("sel_valid", 32'(bus.txValid), 32'd0);
        step();
        chk("hold_valid", 32'(bus.txValid), 32'd1);
        chk("hold_type_null", 32'(bus.txType), 32'd0);
        repeat (8) step();
        cnt = 0;
        for (int i = 0; i < log_type.size(); i++) if (log_type[i] == 2'b00) cnt++;
        chk("null_count", 32'(log_type.size()), 32'd4);
        chk("null_all", 32'(cnt), 32'd4);
        chk("null_no_rd", 32'(rd_cnt), 32'd0);
        chk("null_credit", 32'(bus.creditTx), 32'd0);

        // FCT request / acknowledge
        clear_log();
        ack_cnt = 0;
        bus.sendFctReq = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.sendFctAck) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("fct_ack_seen", 32'(found), 32'd1);
        chk("fct_type", 32'(bus.txType), 32'd1);
        step();
        bus.sendFctReq = 1'b0;
        step();
        chk("after_fct_null", 32'(bus.txType), 32'd0);
        repeat (6) step();
        cnt = 0;
        for (int i = 0; i < log_type.size(); i++) if (log_type[i] == 2'b01) cnt++;
        chk("fct_ack_count", 32'(ack_cnt), 32'd1);
        chk("fct_sent_count", 32'(cnt), 32'd1);

        // Credit gating: 10 queued, 8 credits
        bus.runState = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [8:0] d;
            d = (i == 9) ? 9'h100 : 9'((i * 37 + 5) & 8'hFF);
            push(d);
            exp_q.push_back(d);
        end
        repeat (4) step();
        chk("gate_no_rd", 32'(rd_cnt), 32'd0);
        clear_log();
        rd_cnt = 0;
        bus.gotFct = 1'b1;
        step();
        bus.gotFct = 1'b0;
        chk("gate_credit8", 32'(bus.creditTx), 32'd8);
        repeat (40) step();
        filter_nonnull();
        chk("gate_rd_count", 32'(rd_cnt), 32'd8);
        chk("gate_nchar_count", 32'(nn_type.size()), 32'd8);
        for (int i = 0; i < nn_type.size() && i < 8; i++) begin
            chk("gate_nchar_type", 32'(nn_type[i]), 32'd2);
            chk("gate_nchar_data", 32'(nn_data[i]), 32'(exp_q[i]));
        end
        chk("gate_credit0", 32'(bus.creditTx), 32'd0);
        chk("gate_fifo_left", 32'(fifo_q.size()), 32'd2);
        chk("gate_tail_null", 32'(log_type[log_type.size() - 1]), 32'd0);

        // Simultaneous gotFct and N-Char completion at credit 5
        bus.gotFct = 1'b1;
        step();
        bus.gotFct = 1'b0;
        chk("sim_credit8", 32'(bus.creditTx), 32'd8);
        repeat (20) step();
        chk("sim_credit6", 32'(bus.creditTx), 32'd6);
        chk("sim_fifo_empty", 32'(fifo_q.size()), 32'd0);
        push(9'h0C3);
        repeat (10) step();
        chk("sim_credit5", 32'(bus.creditTx), 32'd5);
        push(9'h05A);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.txValid && (bus.txType == 2'b10)) begin
                found = 1'b1;
                break;
            end
        end
        chk("sim_nchar_hold", 32'(found), 32'd1);
        chk("sim_nchar_data", 32'(bus.txData), 32'h05A);
        bus.gotFct = 1'b1;
        step();
        bus.gotFct = 1'b0;
        chk("sim_credit12", 32'(bus.creditTx), 32'd12);

        // Fill to MAX_CREDIT, then overflow
        bus.enableTx = 1'b0;
        step();
        chk("off_credit", 32'(bus.creditTx), 32'd0);
        chk("off_valid", 32'(bus.txValid), 32'd0);
        bus.enableTx = 1'b1;
        bus.runState = 1'b0;
        step();
        for (int k = 0; k < 7; k++) begin
            bus.gotFct = 1'b1;
            step();
        end
        bus.gotFct = 1'b0;
        chk("ovf_credit56", 32'(bus.creditTx), 32'd56);
        chk("ovf_err_clear", 32'(bus.creditErrTx), 32'd0);
        bus.gotFct = 1'b1;
        step();
        bus.gotFct = 1'b0;
        chk("ovf_credit_keep", 32'(bus.creditTx), 32'd56);
        chk("ovf_err_set", 32'(bus.creditErrTx), 32'd1);
        repeat (3) step();
        chk("ovf_err_sticky", 32'(bus.creditErrTx), 32'd1);

        // Priority: time-code, then FCT, then N-Char
        bus.runState = 1'b1;
        bus.txReady  = 1'b0;
        repeat (4) step();
        push(9'h0E7);
        bus.tickIn     = 1'b1;
        bus.timeIn     = 8'h2A;
        bus.sendFctReq = 1'b1;
        step();
        bus.tickIn = 1'b0;
        clear_log();
        ack_cnt     = 0;
        bus.txReady = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.sendFctAck) begin
                found = 1'b1;
                step();
                bus.sendFctReq = 1'b0;
                break;
            end
        end
        chk("prio_ack_seen", 32'(found), 32'd1);
        repeat (10) step();
        filter_nonnull();
        chk("prio_count", 32'(nn_type.size()), 32'd3);
        if (nn_type.size() == 3) begin
            chk("prio_first_type", 32'(nn_type[0]), 32'd3);
            chk("prio_first_data", 32'(nn_data[0]), 32'h02A);
            chk("prio_second_type", 32'(nn_type[1]), 32'd1);
            chk("prio_second_data", 32'(nn_data[1]), 32'h000);
            chk("prio_third_type", 32'(nn_type[2]), 32'd2);
            chk("prio_third_data", 32'(nn_data[2]), 32'h0E7);
        end
        chk("prio_ack_count", 32'(ack_cnt), 32'd1);
        chk("prio_credit55", 32'(bus.creditTx), 32'd55);

        // Two ticks before sending: one time-code, second value
        bus.txReady = 1'b0;
        repeat (3) step();
        bus.tickIn = 1'b1;
        bus.timeIn = 8'h11;
        step();
        bus.tickIn = 1'b0;
        step();
        bus.tickIn = 1'b1;
        bus.timeIn = 8'h22;
        step();
        bus.tickIn = 1'b0;
        clear_log();
        bus.txReady = 1'b1;
        repeat (10) step();
        filter_nonnull();
        chk("tick2_count", 32'(nn_type.size()), 32'd1);
        if (nn_type.size() == 1) begin
            chk("tick2_type", 32'(nn_type[0]), 32'd3);
            chk("tick2_data", 32'(nn_data[0]), 32'h022);
        end

        // Abort an FCT held in HOLD
        bus.sendFctReq = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.txValid && (bus.txType == 2'b01)) begin
                found = 1'b1;
                break;
            end
        end
        bus.txReady = 1'b0;
        ack_cnt = 0;
        chk("abort_fct_hold", 32'(found), 32'd1);
        step();
        chk("abort_still_valid", 32'(bus.txValid), 32'd1);
        bus.enableTx = 1'b0;
        step();
        chk("abort_valid", 32'(bus.txValid), 32'd0);
        chk("abort_type", 32'(bus.txType), 32'd0);
        chk("abort_credit", 32'(bus.creditTx), 32'd0);
        chk("abort_err", 32'(bus.creditErrTx), 32'd0);
        chk("abort_state", 32'(bus.dbgState), 32'd0);
        bus.sendFctReq = 1'b0;
        step();
        chk("abort_ack_count", 32'(ack_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spwtcr_tx_scheduler.md
Name: spwtcr_tx_scheduler

Overview:
Transmit-side character scheduler for the SpaceWire codec. It sits between the receiver credit logic, the TX FIFO, the time-code input and the TX encoder. Each slot it picks one character to send (time-code, FCT, N-Char or NULL) and tracks the transmit credit granted by FCTs received from the far end. It answers the receiver's FCT request handshake and flags transmit credit errors.

Parameters:
MAX_CREDIT, 56, highest legal transmit credit value.
FCT_CREDIT, 8, credit added per received FCT.

Ports:
CLOCK  in  1  system clock; all logic is on its rising edge.
RESET  in  1  synchronous reset, active-high.
enableTx  in  1  transmitter enabled; low clears state and credit.
runState  in  1  link is in Run; N-Chars and time-codes are allowed only when high.
gotFct  in  1  one-cycle pulse: an FCT was received from the far end.
tickIn  in  1  one-cycle pulse: request to send a time-code.
timeIn  in  8  time-code value, sampled on tickIn.
sendFctReq  in  1  level from the RX credit controller: send one FCT.
sendFctAck  out  1  one-cycle pulse: the FCT has been handed to the encoder.
fifo_empty  in  1  TX FIFO empty.
fifo_data  in  9  show-ahead FIFO head; bit 8 = control flag (EOP/EEP), bits 7:0 = data.
fifo_rd  out  1  one-cycle pop strobe.
txReady  in  1  encoder can accept a character.
txValid  out  1  a character is presented.
txType  out  2  00 NULL, 01 FCT, 10 N-Char, 11 time-code.
txData  out  9  payload: N-Char is fifo_data; time-code is {1'b0,timeIn}; otherwise 0.
creditTx  out  7  current transmit credit.
creditErrTx  out  1  sticky credit overflow flag.

Behaviour:
- Reset (RESET=1): state OFF; all outputs 0; credit 0; tick-pending flag cleared.
- States:
  - OFF: txValid=0, credit=0, creditErrTx=0, tick-pending cleared. Moves to SELECT when enableTx=1.
  - SELECT: one cycle. Chooses the character and loads the output registers. Always moves to HOLD.
  - HOLD: txValid=1, outputs stable. When txValid & txReady, returns to SELECT on the next cycle.
- enableTx=0 in any state: go to OFF on the next clock. A character held in HOLD is discarded; an N-Char already popped is lost.
- Priority in SELECT, highest first:
  - time-code: tick pending and runState.
  - FCT: sendFctReq.
  - N-Char: runState & !fifo_empty & creditTx>0.
  - NULL: otherwise.
- N-Char selection: fifo_rd=1 for exactly the SELECT cycle; fifo_data is captured into txData in that same cycle.
- sendFctAck: pulses for 1 cycle in the cycle the FCT transfer completes (HOLD with txReady=1). The requester drops sendFctReq afterwards; a request still high in the next SELECT cycle sends another FCT.
- Tick handling:
  - tickIn sets tick-pending and captures timeIn.
  - A second tickIn while a tick is pending overwrites the captured value; only one time-code is sent.
  - Tick-pending clears when the time-code transfer completes.
  - A tickIn in the same cycle as that completion re-arms tick-pending.
- Credit update, per cycle (7-bit):
  - gotFct alone: +FCT_CREDIT.
  - completed N-Char transfer alone: -1.
  - both in the same cycle: +FCT_CREDIT-1.
  - A decrement can never occur at 0, because an N-Char is never selected at 0 credit.
- Credit overflow: if the result would exceed MAX_CREDIT, credit keeps its old value and creditErrTx is set. creditErrTx stays set until OFF or RESET.
- Latency: a request seen in SELECT appears on txValid one cycle later. Minimum period is 2 cycles per character with txReady held at 1.

Test Plan:
- Reset/enable: RESET=1 for 2 cycles, then enableTx=1, runState=0, txReady=1 -> NULLs (txType=00) every 2 cycles; fifo_rd stays 0; creditTx=0.
- FCT handshake: sendFctReq=1 held -> txType=01; sendFctAck pulses once when the transfer completes; drop the request the next cycle -> exactly one FCT sent, then NULLs.
- Credit gating: runState=1, FIFO holds 10 chars, one gotFct -> creditTx=8; exactly 8 N-Chars sent with data matching FIFO order; creditTx=0; NULLs afterwards.
- Simultaneous events: gotFct in the same cycle an N-Char completes at credit 5 -> creditTx=12. Seven gotFct pulses from 0 -> 56; an eighth -> creditTx stays 56 and creditErrTx=1.
- Priority/tick: tickIn (timeIn=0x2A), sendFctReq and a non-empty FIFO all at once -> time-code 0x2A first, then FCT, then N-Char. Two ticks before the first is sent -> one time-code carrying the second value.
- Abort: drop enableTx while in HOLD with txReady=0 -> txValid=0 next cycle; creditTx=0; creditErrTx=0; sendFctAck never pulses.
